// File: rtl/load_store_unit_if.sv
// Bundle of every load/store unit signal except clock and reset.
//   master : the load/store unit (accepts requests, drives the memory
//            interface access fields and start pulses, writes back loads)
//   slave  : the environment (execute stage, memory interface, writeback)
// Request channel : req_valid/req_ready handshake plus request fields.
// Memory channel  : mi_* access fields, mi_load/mi_store pulses, and the
//                   mi_data_out/mi_output_valid/mi_write_ready/mi_busy returns.
// Writeback/status: wb_*, err_word_type, err_timeout, lsu_idle.
interface load_store_unit_if #(
  parameter int REG_ADDR_W = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_load;
  logic [12:0]           req_address;
  logic [31:0]           req_data;
  logic [1:0]            req_word_type;
  logic                  req_is_signed;
  logic [REG_ADDR_W-1:0] req_rd;

  logic [12:0]           mi_address;
  logic [31:0]           mi_data_in;
  logic [1:0]            mi_word_type;
  logic                  mi_is_signed;
  logic                  mi_load;
  logic                  mi_store;
  logic [31:0]           mi_data_out;
  logic                  mi_output_valid;
  logic                  mi_write_ready;
  logic                  mi_busy;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [31:0]           wb_data;
  logic                  err_word_type;
  logic                  err_timeout;
  logic                  lsu_idle;

  modport master (
    input  req_valid, req_load, req_address, req_data, req_word_type,
           req_is_signed, req_rd,
    output req_ready,
    output mi_address, mi_data_in, mi_word_type, mi_is_signed, mi_load, mi_store,
    input  mi_data_out, mi_output_valid, mi_write_ready, mi_busy,
    output wb_valid, wb_rd, wb_data, err_word_type, err_timeout, lsu_idle
  );

  modport slave (
    output req_valid, req_load, req_address, req_data, req_word_type,
           req_is_signed, req_rd,
    input  req_ready,
    input  mi_address, mi_data_in, mi_word_type, mi_is_signed, mi_load, mi_store,
    output mi_data_out, mi_output_valid, mi_write_ready, mi_busy,
    input  wb_valid, wb_rd, wb_data, err_word_type, err_timeout, lsu_idle
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and the memory interface.
// Requests are buffered in a FIFO and issued one at a time: the head entry's
// fields are latched onto mi_*, a single-cycle mi_load/mi_store pulse starts
// the access, and the unit waits for the matching completion. Load results
// are written back one cycle after completion. A watchdog aborts accesses
// that never complete; requests with word type 11 are dropped with an error.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-high reset, clears all state
//   bus   : load_store_unit_if master (request, memory and writeback signals)
module load_store_unit #(
  parameter int REG_ADDR_W     = 4,
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.master bus
);
  localparam int         IDX_W     = $clog2(FIFO_DEPTH);
  localparam int         PTR_W     = IDX_W + 1;
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic                  load;
    logic [12:0]           address;
    logic [31:0]           data;
    logic [1:0]            word_type;
    logic                  is_signed;
    logic [REG_ADDR_W-1:0] rd;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  req_t             head, req_in;

  state_t                state, state_n;
  logic                  latch, capture, cnt_inc, err_wt_n, err_to_n;
  logic [7:0]            tmo_cnt;
  logic                  acc_load;
  logic [12:0]           acc_address;
  logic [31:0]           acc_data;
  logic [1:0]            acc_word_type;
  logic                  acc_is_signed;
  logic [REG_ADDR_W-1:0] acc_rd;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [31:0]           wb_data_q;
  logic                  err_wt_q, err_to_q;

  // ---- request FIFO: the head stays queued until its access finishes ----
  assign req_in = '{load:      bus.req_load,
                    address:   bus.req_address,
                    data:      bus.req_data,
                    word_type: bus.req_word_type,
                    is_signed: bus.req_is_signed,
                    rd:        bus.req_rd};

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign push  = bus.req_valid && !full;
  assign head  = fifo_mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[IDX_W-1:0]] <= req_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // ---- sequencer: next state and control ----
  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    latch    = 1'b0;
    capture  = 1'b0;
    cnt_inc  = 1'b0;
    err_wt_n = 1'b0;
    err_to_n = 1'b0;
    case (state)
      IDLE: begin
        // Illegal entries are discarded even while memory is busy.
        if (!empty) begin
          if (head.word_type == 2'b11) begin
            pop      = 1'b1;
            err_wt_n = 1'b1;
          end else if (!bus.mi_busy) begin
            latch   = 1'b1;
            state_n = ISSUE;
          end
        end
      end
      ISSUE, WAIT: begin
        // Only the completion matching the access type is honoured; a
        // completion on the last allowed cycle beats the timeout.
        if (acc_load && bus.mi_output_valid) begin
          capture = 1'b1;
          pop     = 1'b1;
          state_n = WB;
        end else if (!acc_load && bus.mi_write_ready) begin
          pop     = 1'b1;
          state_n = IDLE;
        end else if (state == WAIT && tmo_cnt == TMO_LIMIT) begin
          err_to_n = 1'b1;
          pop      = 1'b1;
          state_n  = IDLE;
        end else begin
          state_n = WAIT;
          cnt_inc = (state == WAIT);
        end
      end
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---- registered access fields, watchdog, writeback and error pulses ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      acc_load      <= 1'b0;
      acc_address   <= '0;
      acc_data      <= '0;
      acc_word_type <= '0;
      acc_is_signed <= 1'b0;
      acc_rd        <= '0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      err_wt_q      <= 1'b0;
      err_to_q      <= 1'b0;
    end else begin
      state    <= state_n;
      err_wt_q <= err_wt_n;
      err_to_q <= err_to_n;
      if (latch) begin
        acc_load      <= head.load;
        acc_address   <= head.address;
        acc_data      <= head.data;
        acc_word_type <= head.word_type;
        acc_is_signed <= head.is_signed;
        acc_rd        <= head.rd;
        tmo_cnt       <= '0;
      end else if (cnt_inc) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (capture) begin
        wb_data_q <= bus.mi_data_out;
        wb_rd_q   <= acc_rd;
      end
    end
  end

  // ---- outputs: all decoded from registers ----
  assign bus.req_ready     = !full;
  assign bus.lsu_idle      = (state == IDLE) && empty;
  assign bus.mi_address    = acc_address;
  assign bus.mi_data_in    = acc_data;
  assign bus.mi_word_type  = acc_word_type;
  assign bus.mi_is_signed  = acc_is_signed;
  assign bus.mi_load       = (state == ISSUE) && acc_load;
  assign bus.mi_store      = (state == ISSUE) && !acc_load;
  assign bus.wb_valid      = (state == WB);
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.err_word_type = err_wt_q;
  assign bus.err_timeout   = err_to_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit. Requests are turned into an ordered
// list of expected observable events (access pulse, writeback, error pulse)
// from a program-order memory model; a monitor pops and compares events as
// the DUT produces them. A responder plays the memory interface.
module tb_load_store_unit;
  localparam int TMO     = 15;
  localparam int K_ACC   = 0;
  localparam int K_WB    = 1;
  localparam int K_ERRWT = 2;
  localparam int K_ERRTO = 3;

  typedef struct {
    int          kind;
    logic        ld;
    logic [12:0] addr;
    logic [31:0] data;
    logic [1:0]  wt;
    logic        sg;
    logic [3:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if #(.REG_ADDR_W(4)) bus();

  load_store_unit #(.REG_ADDR_W(4), .FIFO_DEPTH(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp       = 0;
  int          n_fail      = 0;
  int          cyc         = 0;
  int          busy_force  = 0;
  int          comp_cycle  = -100;
  int          pulse_cycle = -100;
  exp_t        exp_q[$];
  int          lat_q[$];
  logic [31:0] ref_mem  [8192];
  logic [31:0] phys_mem [8192];

  function automatic logic [31:0] init_word(input int a);
    return (a == 16) ? 32'hDEADBEEF : ((32'(a) * 32'h9E3779B1) ^ 32'h0BADF00D);
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // mi_busy changes just after the rising edge; negative force = random
  initial begin
    bus.mi_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.mi_busy = (busy_force < 0) ? ($urandom_range(0, 3) == 0) : (busy_force != 0);
    end
  end

  // Memory interface model: latency per access comes from lat_q (-1 = hang)
  initial begin : responder
    int          lat;
    logic        ld;
    logic [12:0] a;
    logic [31:0] d;
    logic [1:0]  w;
    bus.mi_output_valid = 1'b0;
    bus.mi_write_ready  = 1'b0;
    bus.mi_data_out     = '0;
    for (int i = 0; i < 8192; i++) phys_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!reset && (bus.mi_load || bus.mi_store)) begin
        if (lat_q.size() == 0) begin
          check(1'b0, "access_without_request", 64'(bus.mi_address), 64'(0));
          continue;
        end
        lat = lat_q.pop_front();
        ld  = bus.mi_load;
        a   = bus.mi_address;
        d   = bus.mi_data_in;
        w   = bus.mi_word_type;
        if (lat >= 0) begin
          // wrong-type completion strobes while waiting must be ignored
          for (int i = 0; i < lat; i++) begin
            if (ld) bus.mi_write_ready  = 1'($urandom_range(0, 1));
            else    bus.mi_output_valid = 1'($urandom_range(0, 1));
            bus.mi_data_out = $urandom;
            @(negedge clk);
          end
          check(bus.mi_address == a && bus.mi_data_in == d && bus.mi_word_type == w,
                "field_hold", 64'({bus.mi_address, bus.mi_data_in}), 64'({a, d}));
          comp_cycle = cyc;
          if (ld) begin
            bus.mi_write_ready  = 1'b0;
            bus.mi_data_out     = phys_mem[a];
            bus.mi_output_valid = 1'b1;
          end else begin
            bus.mi_output_valid = 1'b0;
            phys_mem[a]         = d;
            bus.mi_write_ready  = 1'b1;
          end
          @(negedge clk);
          bus.mi_output_valid = 1'b0;
          bus.mi_write_ready  = 1'b0;
        end
      end
    end
  end

  task automatic take(output exp_t e, output bit got);
    got = 1'b0;
    e   = '{K_ACC, 1'b0, 13'h0, 32'h0, 2'b00, 1'b0, 4'h0};
    if (exp_q.size() == 0) check(1'b0, "unexpected_output", 64'(1), 64'(0));
    else begin
      e   = exp_q.pop_front();
      got = 1'b1;
    end
  endtask

  // Monitor: compares every DUT output event with the head of the scoreboard
  initial begin : monitor
    exp_t e;
    bit   got;
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        continue;
      end
      if (bus.mi_load || bus.mi_store) begin
        check(!prev_busy, "issue_while_busy", 64'(prev_busy), 64'(0));
        check(pulse_cycle != cyc - 1 && !(bus.mi_load && bus.mi_store), "single_pulse",
              64'({bus.mi_load, bus.mi_store}), 64'(1));
        pulse_cycle = cyc;
        take(e, got);
        if (got)
          check(e.kind == K_ACC && {e.ld, e.addr, e.data, e.wt, e.sg} ==
                {bus.mi_load, bus.mi_address, bus.mi_data_in, bus.mi_word_type, bus.mi_is_signed},
                "access",
                64'({bus.mi_load, bus.mi_address, bus.mi_data_in, bus.mi_word_type, bus.mi_is_signed}),
                64'({e.ld, e.addr, e.data, e.wt, e.sg}));
      end
      if (bus.wb_valid) begin
        take(e, got);
        if (got) begin
          check(e.kind == K_WB && e.rd == bus.wb_rd && e.data == bus.wb_data, "writeback",
                64'({bus.wb_rd, bus.wb_data}), 64'({e.rd, e.data}));
          check(cyc == comp_cycle + 1, "wb_latency", 64'(cyc - comp_cycle), 64'(1));
        end
      end
      if (bus.err_word_type) begin
        take(e, got);
        if (got) check(e.kind == K_ERRWT, "err_word_type", 64'(K_ERRWT), 64'(e.kind));
      end
      if (bus.err_timeout) begin
        take(e, got);
        if (got) begin
          check(e.kind == K_ERRTO, "err_timeout", 64'(K_ERRTO), 64'(e.kind));
          check(cyc - pulse_cycle == TMO + 1, "timeout_latency",
                64'(cyc - pulse_cycle), 64'(TMO + 1));
        end
      end
      check(!(bus.err_word_type && bus.err_timeout), "err_exclusive",
            64'({bus.err_word_type, bus.err_timeout}), 64'(0));
      prev_busy = bus.mi_busy;
    end
  end

  // Offer one request (caller at a falling edge); on acceptance, record the
  // events program order implies.
  task automatic send(input bit ld, input logic [12:0] addr, input logic [31:0] data,
                      input logic [1:0] wt, input bit sg, input logic [3:0] rd,
                      input int lat);
    int t;
    t = 0;
    bus.req_valid     = 1'b1;
    bus.req_load      = ld;
    bus.req_address   = addr;
    bus.req_data      = data;
    bus.req_word_type = wt;
    bus.req_is_signed = sg;
    bus.req_rd        = rd;
    while (!bus.req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      check(1'b0, "request_accept", 64'(0), 64'(1));
      bus.req_valid = 1'b0;
      return;
    end
    if (wt == 2'b11) begin
      exp_q.push_back('{K_ERRWT, ld, addr, data, wt, sg, rd});
    end else begin
      lat_q.push_back(lat);
      exp_q.push_back('{K_ACC, ld, addr, data, wt, sg, rd});
      if (lat < 0)   exp_q.push_back('{K_ERRTO, ld, addr, data, wt, sg, rd});
      else if (ld)   exp_q.push_back('{K_WB, ld, addr, ref_mem[addr], wt, sg, rd});
      else           ref_mem[addr] = data;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !bus.lsu_idle) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(t < 2000, {"drain_", tag}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached with %0d events outstanding", exp_q.size());
    $fatal(1, "time limit");
  end

  initial begin : main
    int          fall_cyc;
    int          t;
    logic [1:0]  wt;
    int          lat;
    reset             = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_load      = 1'b0;
    bus.req_address   = '0;
    bus.req_data      = '0;
    bus.req_word_type = '0;
    bus.req_is_signed = 1'b0;
    bus.req_rd        = '0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);

    // reset values
    check({bus.mi_load, bus.mi_store, bus.mi_address, bus.mi_data_in, bus.mi_word_type,
           bus.mi_is_signed} == '0, "reset_mi", 64'({bus.mi_load, bus.mi_store, bus.mi_address}), 64'(0));
    check({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.err_word_type, bus.err_timeout} == '0,
          "reset_wb_err", 64'({bus.wb_valid, bus.wb_rd, bus.wb_data}), 64'(0));
    check(bus.req_ready && bus.lsu_idle, "reset_ready_idle",
          64'({bus.req_ready, bus.lsu_idle}), 64'(3));
    reset = 1'b0;
    @(negedge clk);

    // single word load, completion 3 cycles after the pulse
    send(1'b1, 13'h010, 32'h0, 2'b10, 1'b0, 4'd5, 3);
    drain("single_load");

    // three stores offered back to back into a 2-entry FIFO
    send(1'b0, 13'h020, 32'h11111111, 2'b10, 1'b0, 4'd1, 2);
    send(1'b0, 13'h022, 32'h22222222, 2'b10, 1'b0, 4'd1, 2);
    check(!bus.req_ready, "ready_drop_when_full", 64'(bus.req_ready), 64'(0));
    send(1'b0, 13'h024, 32'h33333333, 2'b10, 1'b0, 4'd1, 2);
    drain("stores");

    // illegal word type between two legal loads
    send(1'b1, 13'h020, 32'h0, 2'b10, 1'b1, 4'd3, 1);
    send(1'b0, 13'h100, 32'hABCD0123, 2'b11, 1'b0, 4'd7, 0);
    send(1'b1, 13'h022, 32'h0, 2'b01, 1'b0, 4'd9, 2);
    drain("illegal");

    // memory busy holds off the issue
    busy_force = 1;
    @(negedge clk);
    send(1'b1, 13'h024, 32'h0, 2'b00, 1'b1, 4'd2, 1);
    repeat (10) @(negedge clk);
    busy_force = 0;
    @(posedge clk);
    #1;
    fall_cyc = cyc;
    t = 0;
    while (!bus.mi_load && t < 10) begin
      @(negedge clk);
      t++;
    end
    check(bus.mi_load && cyc == fall_cyc + 1, "busy_release_issue",
          64'(cyc - fall_cyc), 64'(1));
    drain("busy");

    // timeout, then a queued store proceeds; completion on the last
    // allowed WAIT cycle is a completion
    send(1'b1, 13'h030, 32'h0, 2'b10, 1'b0, 4'd4, -1);
    send(1'b0, 13'h030, 32'hCAFEF00D, 2'b10, 1'b0, 4'd0, 1);
    send(1'b1, 13'h030, 32'h0, 2'b10, 1'b0, 4'd11, 0);
    send(1'b1, 13'h031, 32'h0, 2'b10, 1'b1, 4'd8, TMO);
    drain("timeout");

    // randomized traffic with random memory busy
    busy_force = -1;
    for (int n = 0; n < 60; n++) begin
      wt  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      lat = ($urandom_range(0, 9) == 0) ? -1 :
            (($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(0, 4)));
      send(1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)), $urandom, wt,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("random");
    busy_force = 0;
    @(negedge clk);

    // reset while a load is waiting
    send(1'b1, 13'h040, 32'h0, 2'b10, 1'b0, 4'd6, -1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check({bus.mi_load, bus.mi_store, bus.mi_address, bus.mi_data_in, bus.mi_word_type,
           bus.mi_is_signed} == '0, "midreset_mi",
          64'({bus.mi_load, bus.mi_store, bus.mi_address}), 64'(0));
    check({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.err_word_type, bus.err_timeout} == '0,
          "midreset_wb_err", 64'({bus.wb_valid, bus.wb_rd, bus.wb_data}), 64'(0));
    check(bus.req_ready && bus.lsu_idle, "midreset_ready_idle",
          64'({bus.req_ready, bus.lsu_idle}), 64'(3));
    exp_q.delete();
    lat_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check(bus.req_ready && bus.lsu_idle, "post_reset_idle",
          64'({bus.req_ready, bus.lsu_idle}), 64'(3));
    send(1'b1, 13'h022, 32'h0, 2'b10, 1'b0, 4'd12, 1);
    drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
